offset_cmp_pipe: RTL and testbench
==================================

// Module: offset_cmp_pipe
// PURPOSE
//  Parametrised, pipelined offset-compare stage. Each input pair is handled independently:
//  a' = in_a + OFFSET (wraps), then flag = (a' > in_b) || (a' == MAX), and the result is expanded to a mask.
//  Valid/ready handshake on both sides and a saturating hit counter.
//  Sits between operand sources and downstream mask consumers; successor of the 2-bit combinational compare path.
// PARAMETERS
//  WIDTH   2  operand width of in_a/in_b (>=2)
//  OFFSET  1  constant added to in_a, truncated to WIDTH bits
//  OUT_W   2  width of out_ret mask
//  CNT_W   8  width of hit_count
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      input pair valid
//  in_ready   out  1      stage can accept a pair this cycle
//  in_a       in   WIDTH  operand A (offset applied)
//  in_b       in   WIDTH  operand B
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_flag   out  1      compare result
//  out_ret    out  OUT_W  all-ones if out_flag else all-zeros
//  clr_count  in   1      synchronous clear of hit_count
//  hit_count  out  CNT_W  number of accepted results with out_flag=1, saturating
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset values: out_valid=0, out_flag=0, out_ret=0, hit_count=0, both stage-valid bits 0. in_ready=1 after reset.
//  - S1 register: a' = (in_a + OFFSET) mod 2^WIDTH, b.
//  - S2 register: out_flag = (a' > b) | (a' == MAX), and out_ret.
//  - MAX = {WIDTH{1'b1}} (unsigned).
//  - Transfer occurs on valid&ready at each boundary. Latency is exactly 2 cycles from input handshake to out_valid when unstalled.
//  - Throughput is 1 pair/cycle.
//  - Stage advance rule: S2 loads when !out_valid | out_ready. S1 loads when S1 is empty or S1 moves into S2.
//  - in_ready = !s1_valid | s2_load. It is combinational from out_ready; no skid buffer is required.
//  - Stall: while out_valid & !out_ready, out_flag and out_ret hold stable. At most 2 pairs are in flight.
//  - Bubble: S2 loaded from an empty S1 sets out_valid=0.
//  - Counter: +1 on out_valid & out_ready & out_flag. It saturates at 2^CNT_W-1, with no wrap.
//  - clr_count in the same cycle as an increment: clear wins, hit_count=0.
//  - Reset mid-operation drops in-flight pairs; no partial output is emitted.
//  - The offset add wraps silently (e.g. W=2: 3+1 -> 0). There is no carry output.
// CONFIGURATION
//  CMP_SIGNED_EN defined:
//    - a' and b are compared as two's-complement signed.
//    - MAX = {1'b0,{WIDTH-1{1'b1}}} (most positive value).
//    - The offset add still wraps mod 2^WIDTH.
//  CMP_SIGNED_EN undefined: unsigned compare, MAX = all ones.
// TESTING (WIDTH=2, OFFSET=1, OUT_W=2, CNT_W=8 unless noted)
//  1. a=2,b=0 -> 2 cycles later out_valid=1, flag=1, ret=2'b11, hit_count=1.
//     a=0,b=3 -> flag=0, ret=0.
//  2. a=3,b=0 (wrap to 0) -> flag=0. a=2,b=3 (a'=3=MAX) -> flag=1.
//  3. Stream 4 back-to-back pairs with out_ready=0 for 3 cycles:
//     - in_ready drops after 2 accepted.
//     - Output is held stable.
//     - On release, all 4 results arrive in order with no loss or duplication.
//  4. CNT_W=2, send 5 flag=1 results -> hit_count sticks at 3.
//     Assert clr_count on a flag=1 handshake -> 0.
//  5. Assert rst mid-stream -> out_valid=0 and hit_count=0 immediately (async).
//     Resume -> next output is the first pair sent after reset.
//  6. CMP_SIGNED_EN: a=0,b=0 (a'=1=MAX) -> flag=1.
//     a=1,b=1 (a'=-2) -> flag=0 (unsigned build gives 1).

Source files
------------

// File: rtl/offset_cmp_pipe.sv
// Two-stage offset-compare pipeline: a' = in_a + OFFSET, flag = (a' > b) | (a' == MAX), expanded to a mask.
// Define CMP_SIGNED_EN for a two's-complement compare with MAX = most positive value.
module offset_cmp_pipe #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned OFFSET = 1,
    parameter int unsigned OUT_W  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_flag,
    output logic [OUT_W-1:0] out_ret,
    input  logic             clr_count,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [WIDTH-1:0] OFF_V   = WIDTH'(OFFSET);
`ifdef CMP_SIGNED_EN
    localparam logic [WIDTH-1:0] MAX_V   = {1'b0, {(WIDTH-1){1'b1}}};
`else
    localparam logic [WIDTH-1:0] MAX_V   = '1;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s2_flag_q, s2_flag_d;
    logic [OUT_W-1:0] s2_ret_q, s2_ret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s2_load;
    logic s1_load;
    logic flag_c;
    logic hit_inc;

    // Stage advance: S2 frees up when its result is taken, S1 when empty or draining into S2.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

`ifdef CMP_SIGNED_EN
    assign flag_c = ($signed(s1_a_q) > $signed(s1_b_q)) || (s1_a_q == MAX_V);
`else
    assign flag_c = (s1_a_q > s1_b_q) || (s1_a_q == MAX_V);
`endif

    assign hit_inc = s2_valid_q && out_ready && s2_flag_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_flag_d  = s2_flag_q;
        s2_ret_d   = s2_ret_q;
        cnt_d      = cnt_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d = in_a + OFF_V;
                s1_b_d = in_b;
            end
        end

        // An empty S1 moving forward becomes a bubble; payload is left untouched.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_flag_d = flag_c;
                s2_ret_d  = {OUT_W{flag_c}};
            end
        end

        if (clr_count) begin
            cnt_d = '0;
        end else if (hit_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_flag_q  <= 1'b0;
            s2_ret_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_flag_q  <= s2_flag_d;
            s2_ret_q   <= s2_ret_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_flag  = s2_flag_q;
    assign out_ret   = s2_ret_q;
    assign hit_count = cnt_q;

endmodule

// File: tb/tb_offset_cmp_pipe.sv
// Directed bench for offset_cmp_pipe (WIDTH=2, OFFSET=1); a second instance with CNT_W=2 covers saturation.
module tb_offset_cmp_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic       out_ready;
    logic       clr_count;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic       out_flag,  out_flag2;
    logic [1:0] out_ret,   out_ret2;
    logic [7:0] hit_count;
    logic [1:0] hit_count2;

    int checks = 0;
    int errors = 0;
    int exp_hits;

    always #5 clk = ~clk;

    offset_cmp_pipe #(.WIDTH(2), .OFFSET(1), .OUT_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_flag(out_flag), .out_ret(out_ret), .clr_count(clr_count), .hit_count(hit_count)
    );

    offset_cmp_pipe #(.WIDTH(2), .OFFSET(1), .OUT_W(2), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
        .out_flag(out_flag2), .out_ret(out_ret2), .clr_count(clr_count), .hit_count(hit_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_flag(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] ap;
        ap = a + 2'd1;
`ifdef CMP_SIGNED_EN
        return ($signed(ap) > $signed(b)) || (ap == 2'b01);
`else
        return (ap > b) || (ap == 2'b11);
`endif
    endfunction

    function automatic logic [31:0] exp_ret(input logic f);
        return f ? 32'd3 : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two back-to-back pairs with out_ready held high; checks both results and the counter.
    task automatic pair2(input string tag, input logic [1:0] a0, input logic [1:0] b0,
                         input logic [1:0] a1, input logic [1:0] b1);
        logic f0, f1;
        f0 = exp_flag(a0, b0);
        f1 = exp_flag(a1, b1);
        out_ready = 1'b1;
        in_valid  = 1'b1; in_a = a0; in_b = b0;
        tick();
        in_a = a1; in_b = b1;
        check({tag, "_idle"}, 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check({tag, "_v0"}, 32'(out_valid), 32'd1);
        check({tag, "_f0"}, 32'(out_flag), 32'(f0));
        check({tag, "_r0"}, 32'(out_ret), exp_ret(f0));
        check({tag, "_h0"}, 32'(hit_count), 32'(exp_hits));
        if (f0) exp_hits++;
        tick();
        check({tag, "_v1"}, 32'(out_valid), 32'd1);
        check({tag, "_f1"}, 32'(out_flag), 32'(f1));
        check({tag, "_r1"}, 32'(out_ret), exp_ret(f1));
        check({tag, "_h1"}, 32'(hit_count), 32'(exp_hits));
        if (f1) exp_hits++;
        tick();
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
        check({tag, "_h2"}, 32'(hit_count), 32'(exp_hits));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] pa [4];
        logic [1:0] pb [4];
        int sent;
        int rcv;

        pa = '{2'd2, 2'd0, 2'd3, 2'd2};
        pb = '{2'd0, 2'd3, 2'd0, 2'd3};
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1; clr_count = 1'b0; exp_hits = 0;

        // Reset state
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_flag",  32'(out_flag),  32'd0);
        check("rst_ret",   32'(out_ret),   32'd0);
        check("rst_hit",   32'(hit_count), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        #2 rst = 1'b0;
        tick();

        // Basic compare and wrap/MAX cases
        pair2("t1", 2'd2, 2'd0, 2'd0, 2'd3);
        pair2("t2", 2'd3, 2'd0, 2'd2, 2'd3);

        // Four-pair stream with a three-cycle output stall
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 15; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            in_a      = (sent < 4) ? pa[sent] : 2'd0;
            in_b      = (sent < 4) ? pb[sent] : 2'd0;
            #1;
            if (c >= 2 && c <= 4) check("t3_ready_drop", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (rcv < 4) begin
                    check("t3_flag", 32'(out_flag), 32'(exp_flag(pa[rcv], pb[rcv])));
                    check("t3_ret",  32'(out_ret),  exp_ret(exp_flag(pa[rcv], pb[rcv])));
                    if (out_ready) begin
                        if (exp_flag(pa[rcv], pb[rcv])) exp_hits++;
                        rcv++;
                    end
                end else begin
                    check("t3_extra", 32'(out_valid), 32'd0);
                end
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        check("t3_count", 32'(rcv), 32'd4);
        check("t3_hit", 32'(hit_count), 32'(exp_hits));

        // Saturation on the CNT_W=2 instance, then clear winning over an increment
        rst = 1'b1;
        #2 rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 2'd0; in_b = 2'd0;
        repeat (5) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("t4_sat2", 32'(hit_count2), 32'd3);
        check("t4_hit8", 32'(hit_count), 32'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t4_pre_v", 32'(out_valid), 32'd1);
        check("t4_pre_f", 32'(out_flag), 32'd1);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("t4_clr8", 32'(hit_count), 32'd0);
        check("t4_clr2", 32'(hit_count2), 32'd0);

        // Asynchronous reset mid-stream drops in-flight pairs
        in_valid = 1'b1; in_a = 2'd0; in_b = 2'd0;
        tick();
        tick();
        tick();
        check("t5_pre_hit", 32'(hit_count), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_v",   32'(out_valid), 32'd0);
        check("t5_async_h",   32'(hit_count), 32'd0);
        check("t5_async_h2",  32'(hit_count2), 32'd0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        tick();
        check("t5_empty", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_a = 2'd3; in_b = 2'd0;
        tick();
        in_valid = 1'b0;
        check("t5_lat", 32'(out_valid), 32'd0);
        tick();
        check("t5_first_v", 32'(out_valid), 32'd1);
        check("t5_first_f", 32'(out_flag), 32'(exp_flag(2'd3, 2'd0)));
        tick();
        check("t5_drain", 32'(out_valid), 32'd0);

        // Mode-dependent pair: signed build differs on a=1,b=1
        exp_hits = 0;
        pair2("t6", 2'd0, 2'd0, 2'd1, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
